qcv_load_store_unit: RTL and testbench
======================================

QCV_LOAD_STORE_UNIT -- requirements
Module: qcv_load_store_unit

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_i  in  1  synchronous active-high reset.
REQ-004 lsu_req_i  in  1  access request from ID, single-cycle pulse, sampled only in IDLE.
REQ-005 lsu_we_i  in  1  1 = store, 0 = load.
REQ-006 lsu_type_i  in  2  00 word, 01 half, 10 byte; 11 treated as word.
REQ-007 lsu_sign_ext_i  in  1  sign-extend load data.
REQ-008 lsu_wdata_i  in  32  store data (rs2).
REQ-009 adder_result_ex_i  in  32  effective address from EX.
REQ-010 lsu_resp_valid_o  out  1  one-cycle pulse: access fully complete.
REQ-011 lsu_load_err_o / lsu_store_err_o  out  1 each  error qualifier, valid only with lsu_resp_valid_o.
REQ-012 lsu_busy_o  out  1  high whenever state != IDLE.
REQ-013 lsu_rdata_o  out  32  aligned, extended load data; lsu_rdata_valid_o  out  1  load completed without error.
REQ-014 lsu_addr_last_o  out  32  registered original (unaligned) address of the last accepted request, for mtval.
REQ-015 data_req_o  out  1; data_gnt_i  in  1; data_rvalid_i  in  1; data_err_i  in  1 (valid with rvalid).
REQ-016 data_addr_o  out  32 (word-aligned, [1:0]=00); data_we_o  out  1; data_be_o  out  4; data_wdata_o  out  32; data_rdata_i  in  32.

Function
REQ-017 States: IDLE, WAIT_GNT_MIS, WAIT_RVALID_MIS, WAIT_GNT, WAIT_RVALID; at most one bus transaction outstanding.
REQ-018 off = adder_result_ex_i[1:0]; misaligned = (word & off!=0) | (half & off==3); byte never misaligned.
REQ-019 IDLE & lsu_req_i: data_req_o asserted combinationally same cycle, addr = {addr[31:2],00}; accepted request fields and address latched.
REQ-020 IDLE + req + gnt same cycle -> WAIT_RVALID_MIS (misaligned) else WAIT_RVALID; no gnt -> WAIT_GNT_MIS / WAIT_GNT.
REQ-021 In WAIT_GNT*: data_req_o, addr, we, be, wdata held stable from latched values until data_gnt_i.
REQ-022 data_rvalid_i is never expected in the gnt cycle; rvalid in IDLE or WAIT_GNT* SHALL be ignored.
REQ-023 WAIT_RVALID_MIS & rvalid: store data_rdata_i into rdata_q, OR data_err_i into err_q, issue second access (addr first+4, data_req_o high same cycle); gnt -> WAIT_RVALID, else WAIT_GNT.
REQ-024 WAIT_RVALID & rvalid: lsu_resp_valid_o=1 that cycle, -> IDLE; error = err_q | data_err_i routed to load or store error by we.
REQ-025 BE first access: byte 0001<<off; half 0011<<off (off=3 -> 1000); word 1111<<off (truncated to 4 bits). Second access: half 0001; word 1111>>(4-off).
REQ-026 data_wdata_o = lsu_wdata rotated left by 8*off, identical on both accesses.
REQ-027 Load aligned: d = data_rdata_i >> 8*off. Misaligned word: off1 {r2[7:0],q[31:8]}, off2 {r2[15:0],q[31:16]}, off3 {r2[23:0],q[31:24]}; misaligned half: {r2[7:0],q[31:24]}.
REQ-028 Byte/half result zero- or sign-extended per lsu_sign_ext_i; word unmodified.
REQ-029 lsu_rdata_o/lsu_rdata_valid_o combinational in the final rvalid cycle; lsu_rdata_valid_o=0 for stores or any error.
REQ-030 lsu_req_i while busy SHALL be ignored (ID stalls on busy).
REQ-031 Error on first misaligned half SHALL still perform second access; single error reported at end.

Reset
REQ-032 On rst_i: state IDLE, err_q=0, rdata_q=0, lsu_addr_last_o=0; all outputs 0 next cycle (data_req_o, resp, err, busy, rdata_valid, be=0000).
REQ-033 Reset mid-transaction abandons it; later rvalid SHALL be ignored per REQ-022.

Verification
REQ-034 Aligned LW 0x100, gnt same cycle, rvalid +1 with 0xDEADBEEF -> resp_valid+rdata_valid cycle 2, rdata 0xDEADBEEF, be 1111.
REQ-035 LB sign-ext addr 0x103, rdata 0x80112233 -> be 1000, rdata 0xFFFFFF80.
REQ-036 Misaligned LW 0x101, rdata1 0x44332211, rdata2 0x88776655 -> addrs 0x100 then 0x104, be 1110 then 0001, rdata 0x55443322, busy 4+ cycles.
REQ-037 SH 0x203 wdata 0x0000ABCD, gnt delayed 3 cycles -> req/addr/be stable, be 1000 then 0001, wdata 0xCD0000AB both, no rdata_valid.
REQ-038 Misaligned LW, data_err_i on first rvalid -> second access still issued, single resp with load_err=1, rdata_valid=0, addr_last=original address.
REQ-039 rst_i in WAIT_RVALID, rvalid 2 cycles later -> IDLE, no resp_valid, data_req_o 0.

Source files
------------

// File: rtl/qcv_load_store_unit.sv
// Load/store unit: turns one ID-stage access into one or two word-aligned
// bus transactions, splitting misaligned words/halves across two words and
// reassembling the aligned, extended load data on the final response.
module qcv_load_store_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,
    output logic        lsu_resp_valid_o,
    output logic        lsu_load_err_o,
    output logic        lsu_store_err_o,
    output logic        lsu_busy_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rdata_valid_o,
    output logic [31:0] lsu_addr_last_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT_MIS,
        WAIT_RVALID_MIS,
        WAIT_GNT,
        WAIT_RVALID
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [1:0]  type_q, type_d;
    logic        sign_q, sign_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        idle;
    logic [31:0] cur_addr;
    logic        cur_we;
    logic [1:0]  cur_type;
    logic        cur_sign;
    logic [31:0] cur_wdata;
    logic [1:0]  off;
    logic        is_byte;
    logic        is_half;
    logic        cur_mis;
    logic        second;
    logic [3:0]  be_calc;
    logic [31:0] wdata_rot;
    logic [31:0] raw_data;
    logic        final_rvalid;
    logic        final_err;

    // In IDLE the live request drives the bus; afterwards the latched copy does.
    assign idle      = (state_q == IDLE);
    assign cur_addr  = idle ? adder_result_ex_i : addr_q;
    assign cur_we    = idle ? lsu_we_i          : we_q;
    assign cur_type  = idle ? lsu_type_i        : type_q;
    assign cur_sign  = idle ? lsu_sign_ext_i    : sign_q;
    assign cur_wdata = idle ? lsu_wdata_i       : wdata_q;

    assign off     = cur_addr[1:0];
    assign is_byte = (cur_type == 2'b10);
    assign is_half = (cur_type == 2'b01);
    assign cur_mis = (!is_byte && !is_half && off != 2'd0) || (is_half && off == 2'd3);

    // A misaligned access past its first response is always on the upper word.
    assign second = (state_q == WAIT_RVALID_MIS) ||
                    ((state_q == WAIT_GNT || state_q == WAIT_RVALID) && cur_mis);

    assign final_rvalid = (state_q == WAIT_RVALID) && data_rvalid_i;
    assign final_err    = err_q | data_err_i;

    // Byte enables for the lower word, or the spill-over bytes of the upper word.
    always_comb begin
        be_calc = 4'b0000;
        if (second) begin
            if (is_half) be_calc = 4'b0001;
            else         be_calc = 4'b1111 >> (3'd4 - {1'b0, off});
        end else begin
            if (is_byte)      be_calc = 4'b0001 << off;
            else if (is_half) be_calc = 4'b0011 << off;
            else              be_calc = 4'b1111 << off;
        end
    end

    // Store data rotated so each byte lands on its lane in either word.
    always_comb begin
        wdata_rot = cur_wdata;
        case (off)
            2'd1:    wdata_rot = {cur_wdata[23:0], cur_wdata[31:24]};
            2'd2:    wdata_rot = {cur_wdata[15:0], cur_wdata[31:16]};
            2'd3:    wdata_rot = {cur_wdata[7:0],  cur_wdata[31:8]};
            default: wdata_rot = cur_wdata;
        endcase
    end

    // Next-state logic and bus request generation.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        type_d     = type_q;
        sign_d     = sign_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        data_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    data_req_o = 1'b1;
                    addr_d     = adder_result_ex_i;
                    we_d       = lsu_we_i;
                    type_d     = lsu_type_i;
                    sign_d     = lsu_sign_ext_i;
                    wdata_d    = lsu_wdata_i;
                    err_d      = 1'b0;
                    if (data_gnt_i) state_d = cur_mis ? WAIT_RVALID_MIS : WAIT_RVALID;
                    else            state_d = cur_mis ? WAIT_GNT_MIS    : WAIT_GNT;
                end
            end
            WAIT_GNT_MIS: begin
                data_req_o = 1'b1;
                if (data_gnt_i) state_d = WAIT_RVALID_MIS;
            end
            WAIT_RVALID_MIS: begin
                if (data_rvalid_i) begin
                    data_req_o = 1'b1;
                    rdata_d    = data_rdata_i;
                    err_d      = err_q | data_err_i;
                    state_d    = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                data_req_o = 1'b1;
                if (data_gnt_i) state_d = WAIT_RVALID;
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus address/control outputs are quiet whenever no request is driven.
    always_comb begin
        data_addr_o  = 32'd0;
        data_we_o    = 1'b0;
        data_be_o    = 4'b0000;
        data_wdata_o = 32'd0;
        if (data_req_o) begin
            data_addr_o  = second ? {cur_addr[31:2] + 30'd1, 2'b00} : {cur_addr[31:2], 2'b00};
            data_we_o    = cur_we;
            data_be_o    = be_calc;
            data_wdata_o = wdata_rot;
        end
    end

    // Reassemble the addressed bytes, then zero- or sign-extend them.
    always_comb begin
        raw_data = data_rdata_i >> {off, 3'b000};
        if (state_q == WAIT_RVALID && cur_mis) begin
            if (is_half) begin
                raw_data = {16'd0, data_rdata_i[7:0], rdata_q[31:24]};
            end else begin
                case (off)
                    2'd1:    raw_data = {data_rdata_i[7:0],  rdata_q[31:8]};
                    2'd2:    raw_data = {data_rdata_i[15:0], rdata_q[31:16]};
                    default: raw_data = {data_rdata_i[23:0], rdata_q[31:24]};
                endcase
            end
        end
        if (is_byte)      lsu_rdata_o = {{24{cur_sign & raw_data[7]}}, raw_data[7:0]};
        else if (is_half) lsu_rdata_o = {{16{cur_sign & raw_data[15]}}, raw_data[15:0]};
        else              lsu_rdata_o = raw_data;
    end

    assign lsu_resp_valid_o  = final_rvalid;
    assign lsu_load_err_o    = final_rvalid & !we_q & final_err;
    assign lsu_store_err_o   = final_rvalid & we_q & final_err;
    assign lsu_rdata_valid_o = final_rvalid & !we_q & !final_err;
    assign lsu_busy_o        = !idle;
    assign lsu_addr_last_o   = addr_q;

    // State and request registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            type_q  <= 2'b00;
            sign_q  <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            type_q  <= type_d;
            sign_q  <= sign_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_qcv_load_store_unit.sv
// Directed bench for qcv_load_store_unit: aligned, byte, misaligned and
// delayed-grant accesses, error propagation and reset mid-transaction.
module tb_qcv_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_type_i;
    logic        lsu_sign_ext_i;
    logic [31:0] lsu_wdata_i;
    logic [31:0] adder_result_ex_i;
    logic        lsu_resp_valid_o;
    logic        lsu_load_err_o;
    logic        lsu_store_err_o;
    logic        lsu_busy_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_rdata_valid_o;
    logic [31:0] lsu_addr_last_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;

    int checkCount = 0;
    int errCount   = 0;

    qcv_load_store_unit dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .lsu_req_i         (lsu_req_i),
        .lsu_we_i          (lsu_we_i),
        .lsu_type_i        (lsu_type_i),
        .lsu_sign_ext_i    (lsu_sign_ext_i),
        .lsu_wdata_i       (lsu_wdata_i),
        .adder_result_ex_i (adder_result_ex_i),
        .lsu_resp_valid_o  (lsu_resp_valid_o),
        .lsu_load_err_o    (lsu_load_err_o),
        .lsu_store_err_o   (lsu_store_err_o),
        .lsu_busy_o        (lsu_busy_o),
        .lsu_rdata_o       (lsu_rdata_o),
        .lsu_rdata_valid_o (lsu_rdata_valid_o),
        .lsu_addr_last_o   (lsu_addr_last_o),
        .data_req_o        (data_req_o),
        .data_gnt_i        (data_gnt_i),
        .data_rvalid_i     (data_rvalid_i),
        .data_err_i        (data_err_i),
        .data_addr_o       (data_addr_o),
        .data_we_o         (data_we_o),
        .data_be_o         (data_be_o),
        .data_wdata_o      (data_wdata_o),
        .data_rdata_i      (data_rdata_i)
    );

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [1:0] typ,
                                 input logic sign, input logic [31:0] wdata, input logic [31:0] addr);
        lsu_req_i         = req;
        lsu_we_i          = we;
        lsu_type_i        = typ;
        lsu_sign_ext_i    = sign;
        lsu_wdata_i       = wdata;
        adder_result_ex_i = addr;
    endtask

    task automatic setBus(input logic gnt, input logic rvalid, input logic err, input logic [31:0] rdata);
        data_gnt_i    = gnt;
        data_rvalid_i = rvalid;
        data_err_i    = err;
        data_rdata_i  = rdata;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        setBus(1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        idleInputs();
        step();
        step();
        rst_i = 1'b0;
        #3;
        $display("[TB] reset state");
        checkOutput("rst_req",      {31'd0, data_req_o},        32'd0);
        checkOutput("rst_busy",     {31'd0, lsu_busy_o},        32'd0);
        checkOutput("rst_be",       {28'd0, data_be_o},         32'd0);
        checkOutput("rst_resp",     {31'd0, lsu_resp_valid_o},  32'd0);
        checkOutput("rst_rvld",     {31'd0, lsu_rdata_valid_o}, 32'd0);
        checkOutput("rst_addrlast", lsu_addr_last_o,            32'd0);

        // Aligned LW 0x100, granted immediately.
        step();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 32'h100);
        setBus(1'b1, 1'b0, 1'b0, 32'd0);
        #3;
        checkOutput("lw_req",  {31'd0, data_req_o}, 32'd1);
        checkOutput("lw_addr", data_addr_o,         32'h100);
        checkOutput("lw_be",   {28'd0, data_be_o},  32'hF);
        checkOutput("lw_we",   {31'd0, data_we_o},  32'd0);
        step();
        idleInputs();
        setBus(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        #3;
        checkOutput("lw_resp",  {31'd0, lsu_resp_valid_o},  32'd1);
        checkOutput("lw_rvld",  {31'd0, lsu_rdata_valid_o}, 32'd1);
        checkOutput("lw_rdata", lsu_rdata_o,                32'hDEADBEEF);
        checkOutput("lw_lerr",  {31'd0, lsu_load_err_o},    32'd0);
        step();
        idleInputs();
        #3;
        checkOutput("lw_done_busy", {31'd0, lsu_busy_o},       32'd0);
        checkOutput("lw_done_resp", {31'd0, lsu_resp_valid_o}, 32'd0);

        // Sign-extended LB at 0x103.
        step();
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b1, 32'd0, 32'h103);
        setBus(1'b1, 1'b0, 1'b0, 32'd0);
        #3;
        checkOutput("lb_addr", data_addr_o,        32'h100);
        checkOutput("lb_be",   {28'd0, data_be_o}, 32'h8);
        step();
        idleInputs();
        setBus(1'b0, 1'b1, 1'b0, 32'h80112233);
        #3;
        checkOutput("lb_rdata", lsu_rdata_o,                32'hFFFFFF80);
        checkOutput("lb_rvld",  {31'd0, lsu_rdata_valid_o}, 32'd1);

        // Misaligned LW at 0x101 split into 0x100 and 0x104.
        step();
        idleInputs();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 32'h101);
        setBus(1'b1, 1'b0, 1'b0, 32'd0);
        #3;
        checkOutput("mlw_addr1", data_addr_o,        32'h100);
        checkOutput("mlw_be1",   {28'd0, data_be_o}, 32'hE);
        step();
        idleInputs();
        #3;
        checkOutput("mlw_busy",    {31'd0, lsu_busy_o}, 32'd1);
        checkOutput("mlw_noreq",   {31'd0, data_req_o}, 32'd0);
        step();
        setBus(1'b1, 1'b1, 1'b0, 32'h44332211);
        #3;
        checkOutput("mlw_req2",  {31'd0, data_req_o},       32'd1);
        checkOutput("mlw_addr2", data_addr_o,               32'h104);
        checkOutput("mlw_be2",   {28'd0, data_be_o},        32'h1);
        checkOutput("mlw_resp1", {31'd0, lsu_resp_valid_o}, 32'd0);
        step();
        setBus(1'b0, 1'b1, 1'b0, 32'h88776655);
        #3;
        checkOutput("mlw_resp",  {31'd0, lsu_resp_valid_o},  32'd1);
        checkOutput("mlw_rdata", lsu_rdata_o,                32'h55443322);
        checkOutput("mlw_rvld",  {31'd0, lsu_rdata_valid_o}, 32'd1);

        // SH at 0x203 with a grant delayed by three cycles.
        step();
        idleInputs();
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000ABCD, 32'h203);
        #3;
        checkOutput("sh_req",   {31'd0, data_req_o}, 32'd1);
        checkOutput("sh_addr",  data_addr_o,         32'h200);
        checkOutput("sh_be",    {28'd0, data_be_o},  32'h8);
        checkOutput("sh_wdata", data_wdata_o,        32'hCD0000AB);
        checkOutput("sh_we",    {31'd0, data_we_o},  32'd1);
        for (int i = 1; i < 3; i++) begin
            step();
            idleInputs();
            if (i == 2) setBus(1'b0, 1'b1, 1'b1, 32'h12345678);
            #3;
            checkOutput($sformatf("sh_hold_req%0d", i),  {31'd0, data_req_o},       32'd1);
            checkOutput($sformatf("sh_hold_addr%0d", i), data_addr_o,               32'h200);
            checkOutput($sformatf("sh_hold_be%0d", i),   {28'd0, data_be_o},        32'h8);
            checkOutput($sformatf("sh_hold_resp%0d", i), {31'd0, lsu_resp_valid_o}, 32'd0);
        end
        step();
        setBus(1'b1, 1'b0, 1'b0, 32'd0);
        #3;
        checkOutput("sh_gnt_req", {31'd0, data_req_o}, 32'd1);
        step();
        setBus(1'b1, 1'b1, 1'b0, 32'd0);
        #3;
        checkOutput("sh_addr2",  data_addr_o,        32'h204);
        checkOutput("sh_be2",    {28'd0, data_be_o}, 32'h1);
        checkOutput("sh_wdata2", data_wdata_o,       32'hCD0000AB);
        step();
        setBus(1'b0, 1'b1, 1'b0, 32'd0);
        #3;
        checkOutput("sh_resp", {31'd0, lsu_resp_valid_o},  32'd1);
        checkOutput("sh_rvld", {31'd0, lsu_rdata_valid_o}, 32'd0);
        checkOutput("sh_serr", {31'd0, lsu_store_err_o},   32'd0);

        // Misaligned LW at 0x302 with a bus error on the first response.
        step();
        idleInputs();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 32'h302);
        setBus(1'b1, 1'b0, 1'b0, 32'd0);
        #3;
        checkOutput("err_be1", {28'd0, data_be_o}, 32'hC);
        step();
        idleInputs();
        setBus(1'b1, 1'b1, 1'b1, 32'hAAAAAAAA);
        #3;
        checkOutput("err_req2",  {31'd0, data_req_o},       32'd1);
        checkOutput("err_addr2", data_addr_o,               32'h304);
        checkOutput("err_be2",   {28'd0, data_be_o},        32'h3);
        checkOutput("err_resp1", {31'd0, lsu_resp_valid_o}, 32'd0);
        step();
        setBus(1'b0, 1'b1, 1'b0, 32'h55555555);
        #3;
        checkOutput("err_resp",     {31'd0, lsu_resp_valid_o},  32'd1);
        checkOutput("err_lerr",     {31'd0, lsu_load_err_o},    32'd1);
        checkOutput("err_serr",     {31'd0, lsu_store_err_o},   32'd0);
        checkOutput("err_rvld",     {31'd0, lsu_rdata_valid_o}, 32'd0);
        checkOutput("err_addrlast", lsu_addr_last_o,            32'h302);

        // Misaligned sign-extended LH at 0x103.
        step();
        idleInputs();
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'd0, 32'h103);
        setBus(1'b1, 1'b0, 1'b0, 32'd0);
        #3;
        checkOutput("mlh_be1", {28'd0, data_be_o}, 32'h8);
        step();
        idleInputs();
        setBus(1'b1, 1'b1, 1'b0, 32'hAB000000);
        #3;
        checkOutput("mlh_be2", {28'd0, data_be_o}, 32'h1);
        step();
        setBus(1'b0, 1'b1, 1'b0, 32'h000000CD);
        #3;
        checkOutput("mlh_rdata", lsu_rdata_o, 32'hFFFFCDAB);

        // Aligned zero-extended LH at 0x202.
        step();
        idleInputs();
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'd0, 32'h202);
        setBus(1'b1, 1'b0, 1'b0, 32'd0);
        #3;
        checkOutput("lh_be", {28'd0, data_be_o}, 32'hC);
        step();
        idleInputs();
        setBus(1'b0, 1'b1, 1'b0, 32'h80011234);
        #3;
        checkOutput("lh_rdata", lsu_rdata_o, 32'h00008001);

        // Reset while waiting for rvalid; the late rvalid must be ignored.
        step();
        idleInputs();
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 32'h400);
        setBus(1'b1, 1'b0, 1'b0, 32'd0);
        step();
        idleInputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #3;
        checkOutput("rstmid_busy", {31'd0, lsu_busy_o}, 32'd0);
        step();
        setBus(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
        #3;
        checkOutput("rstmid_resp", {31'd0, lsu_resp_valid_o}, 32'd0);
        checkOutput("rstmid_req",  {31'd0, data_req_o},       32'd0);
        step();
        idleInputs();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
